// File: rtl/reg_dest_select_pipe.sv
// reg_dest_select_pipe: picks the write destination (rt, rd or LINK_REG) in ID
// and carries it plus its write-valid through DEPTH stages (stage 0 = EX,
// stage DEPTH-1 = WB). Stage 0 holds on stall and a bubble enters stage 1;
// flush kills the instruction entering stage 0 and overrides stall.
// DEPTH legal range is 2..8.
// Optional feature macro: REG_DEST_FWD_MATCH_EN adds src_a/src_b inputs and
// per-stage match_a/match_b hit vectors for the forwarding unit.

// One pipeline slot: hold keeps contents, bubble loads an empty entry,
// otherwise the slot loads d_*.
module reg_dest_stage #(
  parameter int ADDR_W = 5
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              hold,
  input  logic              bubble,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic              d_vld,
  output logic [ADDR_W-1:0] q_addr,
  output logic              q_vld
);

  // Slot register: hold has priority over bubble, bubble over load.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q_addr <= '0;
      q_vld  <= 1'b0;
    end else if (hold) begin
      q_addr <= q_addr;
      q_vld  <= q_vld;
    end else if (bubble) begin
      q_addr <= '0;
      q_vld  <= 1'b0;
    end else begin
      q_addr <= d_addr;
      q_vld  <= d_vld;
    end
  end

endmodule

module reg_dest_select_pipe #(
  parameter int ADDR_W   = 5,
  parameter int LINK_REG = 31,
  parameter int DEPTH    = 3
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [ADDR_W-1:0]       id_rt,
  input  logic [ADDR_W-1:0]       id_rd,
  input  logic [1:0]              id_dst_sel,
  input  logic                    id_reg_write,
  input  logic                    stall,
  input  logic                    flush,
  output logic [DEPTH*ADDR_W-1:0] stg_addr,
  output logic [DEPTH-1:0]        stg_vld,
  output logic [ADDR_W-1:0]       wb_addr,
  output logic                    wb_we
`ifdef REG_DEST_FWD_MATCH_EN
  ,
  input  logic [ADDR_W-1:0]       src_a,
  input  logic [ADDR_W-1:0]       src_b,
  output logic [DEPTH-1:0]        match_a,
  output logic [DEPTH-1:0]        match_b
`endif
);

  localparam logic [ADDR_W-1:0] LINK = ADDR_W'(LINK_REG);

  logic [ADDR_W-1:0]             sel;
  logic                          nv;
  logic                          stall_eff;
  logic [DEPTH-1:0]              hold_v;
  logic [DEPTH-1:0]              bub_v;
  logic [DEPTH-1:0][ADDR_W-1:0]  d_addr;
  logic [DEPTH-1:0]              d_vld;
  logic [DEPTH-1:0][ADDR_W-1:0]  q_addr;
  logic [DEPTH-1:0]              vld_pipe;

  // Destination select in ID; code 11 is reserved and falls back to rt.
  always_comb begin
    sel = id_rt;
    case (id_dst_sel)
      2'b01:   sel = id_rd;
      2'b10:   sel = LINK;
      default: sel = id_rt;
    endcase
  end

  // Register 0 is hardwired, so a write to it is carried but never enabled.
  assign nv        = id_reg_write && (sel != '0);
  // Flush wins over stall: a flushed cycle advances the pipe normally.
  assign stall_eff = stall && !flush;

  genvar k;
  generate
    for (k = 0; k < DEPTH; k++) begin : g_stg
      if (k == 0) begin : g_ex
        // Stage 0 captures the ID selection; flush stores it as invalid.
        assign hold_v[k] = stall_eff;
        assign bub_v[k]  = 1'b0;
        assign d_addr[k] = sel;
        assign d_vld[k]  = nv && !flush;
      end else if (k == 1) begin : g_mem
        // Stage 1 takes a bubble while stage 0 is held.
        assign hold_v[k] = 1'b0;
        assign bub_v[k]  = stall_eff;
        assign d_addr[k] = q_addr[k-1];
        assign d_vld[k]  = vld_pipe[k-1];
      end else begin : g_tail
        // Later stages always drain; stall never freezes them.
        assign hold_v[k] = 1'b0;
        assign bub_v[k]  = 1'b0;
        assign d_addr[k] = q_addr[k-1];
        assign d_vld[k]  = vld_pipe[k-1];
      end

      reg_dest_stage #(.ADDR_W(ADDR_W)) u_stage (
        .clk    (clk),
        .rst_n  (rst_n),
        .hold   (hold_v[k]),
        .bubble (bub_v[k]),
        .d_addr (d_addr[k]),
        .d_vld  (d_vld[k]),
        .q_addr (q_addr[k]),
        .q_vld  (vld_pipe[k])
      );

      assign stg_addr[k*ADDR_W +: ADDR_W] = q_addr[k];

`ifdef REG_DEST_FWD_MATCH_EN
      // Hit when a live stage writes the register ID is about to read.
      assign match_a[k] = vld_pipe[k] && (q_addr[k] == src_a) && (src_a != '0);
      assign match_b[k] = vld_pipe[k] && (q_addr[k] == src_b) && (src_b != '0);
`endif
    end
  endgenerate

  assign stg_vld = vld_pipe;
  assign wb_addr = q_addr[DEPTH-1];
  assign wb_we   = vld_pipe[DEPTH-1];

endmodule

// File: tb/tb_reg_dest_select_pipe.sv
// Bench for reg_dest_select_pipe: directed scenarios plus random traffic.
// A reference model tracks what sits in stage 0 and pushes every valid write
// leaving stage 0 into a queue; a negedge monitor checks stage 0 against the
// model and pops the queue whenever wb_we is seen.
module tb_reg_dest_select_pipe;
  localparam int AW = 5;
  localparam int D  = 3;
  localparam int LR = 31;

  logic              clk = 1'b0;
  logic              rst_n;
  logic [AW-1:0]     id_rt, id_rd;
  logic [1:0]        id_dst_sel;
  logic              id_reg_write, stall, flush;
  logic [D*AW-1:0]   stg_addr;
  logic [D-1:0]      stg_vld;
  logic [AW-1:0]     wb_addr;
  logic              wb_we;
`ifdef REG_DEST_FWD_MATCH_EN
  logic [AW-1:0]     src_a, src_b;
  logic [D-1:0]      match_a, match_b;
`endif

  reg_dest_select_pipe #(.ADDR_W(AW), .LINK_REG(LR), .DEPTH(D)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .id_rt        (id_rt),
    .id_rd        (id_rd),
    .id_dst_sel   (id_dst_sel),
    .id_reg_write (id_reg_write),
    .stall        (stall),
    .flush        (flush),
    .stg_addr     (stg_addr),
    .stg_vld      (stg_vld),
    .wb_addr      (wb_addr),
    .wb_we        (wb_we)
`ifdef REG_DEST_FWD_MATCH_EN
    ,
    .src_a        (src_a),
    .src_b        (src_b),
    .match_a      (match_a),
    .match_b      (match_b)
`endif
  );

  always #5 clk = ~clk;

  int            checks = 0;
  int            errors = 0;
  logic          mon_en = 1'b0;
  logic [AW-1:0] m0_addr;
  logic          m0_vld;
  logic [AW-1:0] exp_q[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Drive one ID cycle, let it be clocked, then advance the model.
  task automatic step(input logic [AW-1:0] rt, input logic [AW-1:0] rd,
                      input logic [1:0] ds, input logic we,
                      input logic st, input logic fl);
    logic [AW-1:0] s;
    logic          v;
    id_rt = rt; id_rd = rd; id_dst_sel = ds; id_reg_write = we;
    stall = st; flush = fl;
    @(posedge clk);
    s = (ds == 2'b10) ? AW'(LR) : (ds == 2'b01) ? rd : rt;
    v = we && (s != 0);
    if (fl) begin
      if (m0_vld) exp_q.push_back(m0_addr);
      m0_addr = s; m0_vld = 1'b0;
    end else if (!st) begin
      if (m0_vld) exp_q.push_back(m0_addr);
      m0_addr = s; m0_vld = v;
    end
    #1;
  endtask

  task automatic idle();
    step('0, '0, 2'b00, 1'b0, 1'b0, 1'b0);
  endtask

  // Assert reset between edges and confirm outputs clear without a clock.
  task automatic do_reset();
    #2;
    rst_n = 1'b0;
    #1;
    chk("rst_async_vld", 32'(stg_vld), 32'd0);
    chk("rst_async_addr", 32'(stg_addr), 32'd0);
    chk("rst_async_we", 32'(wb_we), 32'd0);
    m0_addr = '0; m0_vld = 1'b0;
    exp_q.delete();
    @(posedge clk);
    #2;
    rst_n = 1'b1;
  endtask

  // Monitor: stage 0 against the model, write-back against the scoreboard.
  always @(negedge clk) begin
    if (rst_n && mon_en) begin
      chk("stg0_addr", 32'(stg_addr[AW-1:0]), 32'(m0_addr));
      chk("stg0_vld", 32'(stg_vld[0]), 32'(m0_vld));
      chk("wb_we_alias", 32'(wb_we), 32'(stg_vld[D-1]));
      if (wb_we) begin
        if (exp_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL wb_unexpected: got write to %0d expected none at %0t", wb_addr, $time);
        end else begin
          chk("wb_addr_sb", 32'(wb_addr), 32'(exp_q.pop_front()));
        end
      end
    end
  end

  initial begin
    id_rt = '0; id_rd = '0; id_dst_sel = '0; id_reg_write = 1'b0;
    stall = 1'b0; flush = 1'b0;
    m0_addr = '0; m0_vld = 1'b0;
`ifdef REG_DEST_FWD_MATCH_EN
    src_a = 5'd3; src_b = 5'd0;
`endif
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_vld", 32'(stg_vld), 32'd0);
    chk("reset_addr", 32'(stg_addr), 32'd0);
    chk("reset_we", 32'(wb_we), 32'd0);
`ifdef REG_DEST_FWD_MATCH_EN
    chk("reset_match_a", 32'(match_a), 32'd0);
`endif
    #1;
    rst_n = 1'b1;
    mon_en = 1'b1;

    // Reset mid-stream while stall and flush are high, then rd=7 reaches WB.
    step(5'd1, 5'd2, 2'b01, 1'b1, 1'b0, 1'b0);
    step(5'd3, 5'd4, 2'b00, 1'b1, 1'b1, 1'b1);
    do_reset();
    step(5'd0, 5'd7, 2'b01, 1'b1, 1'b0, 1'b0);
    idle();
    chk("rst_rd7_not_yet", 32'(wb_we), 32'd0);
    idle();
    chk("rst_rd7_wb_addr", 32'(wb_addr), 32'd7);
    chk("rst_rd7_wb_we", 32'(wb_we), 32'd1);

    // Select decode on consecutive cycles.
    step(5'd4, 5'd1, 2'b00, 1'b1, 1'b0, 1'b0);
    chk("sel00_rt", 32'(stg_addr[AW-1:0]), 32'd4);
    step(5'd2, 5'd9, 2'b01, 1'b1, 1'b0, 1'b0);
    chk("sel01_rd", 32'(stg_addr[AW-1:0]), 32'd9);
    step(5'd2, 5'd3, 2'b10, 1'b1, 1'b0, 1'b0);
    chk("sel10_link", 32'(stg_addr[AW-1:0]), 32'd31);
    step(5'd6, 5'd3, 2'b11, 1'b1, 1'b0, 1'b0);
    chk("sel11_rt", 32'(stg_addr[AW-1:0]), 32'd6);

    // Write to register 0 never enables.
    step(5'd3, 5'd0, 2'b01, 1'b1, 1'b0, 1'b0);
    chk("zero_stg0_vld", 32'(stg_vld[0]), 32'd0);
    idle(); idle();
    chk("zero_wb_we", 32'(wb_we), 32'd0);

    // Two-cycle stall on rd=5.
    step(5'd0, 5'd5, 2'b01, 1'b1, 1'b0, 1'b0);
    step(5'd0, 5'd5, 2'b01, 1'b1, 1'b1, 1'b0);
    chk("stall1_addr0", 32'(stg_addr[AW-1:0]), 32'd5);
    chk("stall1_vld0", 32'(stg_vld[0]), 32'd1);
    chk("stall1_bubble", 32'(stg_vld[1]), 32'd0);
    step(5'd0, 5'd5, 2'b01, 1'b1, 1'b1, 1'b0);
    chk("stall2_vld0", 32'(stg_vld[0]), 32'd1);
    chk("stall2_bubble_addr", 32'(stg_addr[AW +: AW]), 32'd0);
    chk("stall2_bubble", 32'(stg_vld[1]), 32'd0);
    idle();
    chk("stall_edge4_we", 32'(wb_we), 32'd0);
    idle();
    chk("stall_edge5_addr", 32'(wb_addr), 32'd5);
    chk("stall_edge5_we", 32'(wb_we), 32'd1);

    // Flush and stall together: rd=12 is killed, old stage 0 moves on.
    step(5'd0, 5'd10, 2'b01, 1'b1, 1'b0, 1'b0);
    step(5'd0, 5'd12, 2'b01, 1'b1, 1'b1, 1'b1);
    chk("flush_vld0", 32'(stg_vld[0]), 32'd0);
    chk("flush_addr1", 32'(stg_addr[AW +: AW]), 32'd10);
    chk("flush_vld1", 32'(stg_vld[1]), 32'd1);
    idle();
    chk("flush_wb10", 32'(wb_addr), 32'd10);
    idle();
    chk("flush_no_wb12", 32'(wb_we), 32'd0);
    idle();

`ifdef REG_DEST_FWD_MATCH_EN
    step(5'd0, 5'd3, 2'b01, 1'b1, 1'b0, 1'b0);
    step(5'd0, 5'd8, 2'b01, 1'b1, 1'b0, 1'b0);
    step(5'd0, 5'd3, 2'b01, 1'b1, 1'b0, 1'b0);
    chk("fwd_match_a", 32'(match_a), 32'b101);
    chk("fwd_match_b", 32'(match_b), 32'b000);
`endif

    // Random traffic with occasional resets.
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(99) == 0) do_reset();
      step(AW'($urandom), AW'($urandom), 2'($urandom),
           $urandom_range(3) != 0, $urandom_range(3) == 0,
           $urandom_range(9) == 0);
    end
    repeat (D + 2) idle();
    chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
